// File: rtl/adder_pkg.sv
// Shared RSA datapath constants and the adder FSM state type.
package adder_pkg;

   localparam int RSA_WIDTH  = 514;
   localparam int RSA_WORD_W = 64;

   // Number of WORD_W slices needed to cover a WIDTH+1 bit result
   function automatic int nwords_f(input int width, input int word_w);
      return (width + 1 + word_w - 1) / word_w;
   endfunction

   localparam int RSA_NWORDS = nwords_f(RSA_WIDTH, RSA_WORD_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } adder_state_e;

endpackage

// File: rtl/adder_if.sv
// Operand/result bundle between the Montgomery controller and the adder.
interface adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
);
   logic             start;
   logic             subtract;
   logic             shift;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH:0]   result;
   logic             done;

   modport master (
      output start, subtract, shift, in_a, in_b,
      input  result, done
   );

   modport slave (
      input  start, subtract, shift, in_a, in_b,
      output result, done
   );
endinterface

// File: rtl/adder_word.sv
// One WORD_W-bit carry-chain slice: a + (b or ~b) + carry_in.
module adder_word
   import adder_pkg::*;
#(
   parameter int WORD_W = RSA_WORD_W
) (
   input  logic [WORD_W-1:0] a_word,
   input  logic [WORD_W-1:0] b_word,
   input  logic              invert_b,
   input  logic              carry_in,
   output logic [WORD_W-1:0] sum_word,
   output logic              carry_out
);
   logic [WORD_W:0] total_s;

   // Full-width sum including the carry into the next slice
   always_comb begin
      total_s = {1'b0, a_word}
              + {1'b0, b_word ^ {WORD_W{invert_b}}}
              + {{WORD_W{1'b0}}, carry_in};
   end

   assign sum_word  = total_s[WORD_W-1:0];
   assign carry_out = total_s[WORD_W];
endmodule

// File: rtl/adder.sv
// Word-serial multi-precision add/subtract with an in-place right-shift result register.
module adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = RSA_WIDTH,
   parameter int WORD_W = RSA_WORD_W
) (
   input logic   clk,
   input logic   reset,
   adder_if.slave bus
);
   localparam int NWORDS = nwords_f(WIDTH, WORD_W);
   localparam int EXT_W  = NWORDS * WORD_W;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

   adder_state_e     state_r;
   adder_state_e     state_next_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             sub_r;
   logic             carry_r;
   logic             done_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH:0]   result_r;

   logic             load_s;
   logic             step_s;
   logic             shift_s;
   logic             last_s;

   logic [EXT_W-1:0]  a_ext_s;
   logic [EXT_W-1:0]  b_ext_s;
   logic [EXT_W-1:0]  res_ext_s;
   logic [WORD_W-1:0] a_word_s;
   logic [WORD_W-1:0] b_word_s;
   logic [WORD_W-1:0] sum_word_s;
   logic              carry_out_s;
   logic [WIDTH:0]    result_next_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; start is only honoured outside BUSY
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) state_next_s = ST_BUSY;
            else           state_next_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (last_s) state_next_s = ST_DONE;
            else        state_next_s = ST_BUSY;
         end
         ST_DONE: begin
            if (bus.start) state_next_s = ST_BUSY;
            else           state_next_s = ST_DONE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM output strobes; start takes priority over shift
   always_comb begin
      load_s  = 1'b0;
      step_s  = 1'b0;
      shift_s = 1'b0;
      last_s  = (cnt_r == LAST_CNT);
      case (state_r)
         ST_IDLE, ST_DONE: begin
            load_s  = bus.start;
            shift_s = bus.shift & ~bus.start;
         end
         ST_BUSY: begin
            step_s = 1'b1;
         end
         default: begin
            load_s  = 1'b0;
            step_s  = 1'b0;
            shift_s = 1'b0;
         end
      endcase
   end

   // Select the current operand slices from the zero-extended operands
   always_comb begin
      a_ext_s  = EXT_W'(a_r);
      b_ext_s  = EXT_W'(b_r);
      a_word_s = a_ext_s[int'(cnt_r) * WORD_W +: WORD_W];
      b_word_s = b_ext_s[int'(cnt_r) * WORD_W +: WORD_W];
   end

   adder_word #(.WORD_W(WORD_W)) u_word (
      .a_word    (a_word_s),
      .b_word    (b_word_s),
      .invert_b  (sub_r),
      .carry_in  (carry_r),
      .sum_word  (sum_word_s),
      .carry_out (carry_out_s)
   );

   // Merge the new sum slice into the result; slice bits above WIDTH are dropped
   always_comb begin
      res_ext_s = EXT_W'(result_r);
      res_ext_s[int'(cnt_r) * WORD_W +: WORD_W] = sum_word_s;
      result_next_s = res_ext_s[WIDTH:0];
   end

   generate
      if (EXT_W > WIDTH + 1) begin : g_pad
         logic unused_s;
         assign unused_s = ^res_ext_s[EXT_W-1:WIDTH+1];
      end
   endgenerate

   // Datapath: operand capture, word accumulation, carry, shift and done flag
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         sub_r    <= 1'b0;
         carry_r  <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         result_r <= {(WIDTH+1){1'b0}};
         done_r   <= 1'b0;
      end else if (load_s) begin
         a_r      <= bus.in_a;
         b_r      <= bus.in_b;
         sub_r    <= bus.subtract;
         carry_r  <= bus.subtract;
         cnt_r    <= {CNT_W{1'b0}};
         result_r <= {(WIDTH+1){1'b0}};
         done_r   <= 1'b0;
      end else if (step_s) begin
         result_r <= result_next_s;
         carry_r  <= carry_out_s;
         if (last_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            done_r <= 1'b1;
         end else begin
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            done_r <= 1'b0;
         end
      end else if (shift_s) begin
         result_r <= {1'b0, result_r[WIDTH:1]};
      end else begin
         result_r <= result_r;
      end
   end

   assign bus.result = result_r;
   assign bus.done   = done_r;
endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the word-serial adder: vector table, corner sequences, random ops.
module tb_adder;
   import adder_pkg::*;

   localparam int W     = RSA_WIDTH;
   localparam int NW    = RSA_NWORDS;
   localparam int LIMIT = 40;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   adder_if #(.WIDTH(W)) bus ();

   adder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W:0]   exp;
   } vec_t;

   vec_t vecs[7];

   // Reference: plain (W+1)-bit modular arithmetic
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
      logic [W:0] ea;
      logic [W:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      if (sub) return ea - eb;
      else     return ea + eb;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
      return t[W-1:0];
   endfunction

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one operation starting at a negedge; returns at the negedge where done is seen
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic disturb, input logic with_shift, input string name);
      int cycles;
      logic [W:0] exp;
      exp = ref_op(a, b, sub);
      bus.start    = 1'b1;
      bus.shift    = with_shift;
      bus.subtract = sub;
      bus.in_a     = a;
      bus.in_b     = b;
      @(negedge clk);
      chk({name, "_done_low"}, (W+1)'(bus.done), (W+1)'(0));
      chk({name, "_cleared"}, bus.result, (W+1)'(0));
      cycles = 0;
      while (!bus.done && cycles < LIMIT) begin
         bus.start    = disturb && (cycles == 3);
         bus.shift    = disturb && (cycles == 3);
         bus.in_a     = rand_w();
         bus.in_b     = rand_w();
         bus.subtract = $urandom_range(0, 1) == 1;
         @(negedge clk);
         cycles++;
      end
      bus.start = 1'b0;
      bus.shift = 1'b0;
      chk({name, "_latency"}, (W+1)'(cycles), (W+1)'(NW));
      chk({name, "_result"}, bus.result, exp);
   endtask

   task automatic do_shift(input int k, input logic [W:0] exp, input string name);
      for (int i = 0; i < k; i++) begin
         bus.shift = 1'b1;
         @(negedge clk);
      end
      bus.shift = 1'b0;
      chk({name, "_shift"}, bus.result, exp);
      chk({name, "_shift_done"}, (W+1)'(bus.done), (W+1)'(1));
   endtask

   initial begin
      logic [W:0] held;
      logic [W:0] exp;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rs;
      int k;
      checks = 0;
      errors = 0;

      vecs[0] = '{a: W'(1), b: W'(1), sub: 1'b0, exp: (W+1)'(2)};
      vecs[1] = '{a: W'(1), b: W'(1), sub: 1'b1, exp: (W+1)'(0)};
      vecs[2] = '{a: {W{1'b1}}, b: {W{1'b1}}, sub: 1'b0, exp: {1'b1, {(W-1){1'b1}}, 1'b0}};
      vecs[3] = '{a: W'(0), b: W'(1), sub: 1'b1, exp: {(W+1){1'b1}}};
      vecs[4] = '{a: W'(64'hFFFF_FFFF_FFFF_FFFF), b: W'(1), sub: 1'b0,
                  exp: (W+1)'(1) << 64};
      vecs[5] = '{a: W'(1) << (W-1), b: W'(1) << (W-1), sub: 1'b0, exp: (W+1)'(1) << W};
      vecs[6] = '{a: W'(5), b: W'(7), sub: 1'b1, exp: {{W{1'b1}}, 1'b0}};

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.shift    = 1'b0;
      bus.subtract = 1'b0;
      bus.in_a     = {W{1'b0}};
      bus.in_b     = {W{1'b0}};
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_result", bus.result, (W+1)'(0));
      chk("reset_done", (W+1)'(bus.done), (W+1)'(0));

      // 1+1 then done held over idle cycles
      do_op(W'(1), W'(1), 1'b0, 1'b0, 1'b0, "one_plus_one");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("done_hold", (W+1)'(bus.done), (W+1)'(1));
         chk("result_hold", bus.result, (W+1)'(2));
      end

      // Table vectors, issued back-to-back
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, 1'b0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_table", i), bus.result, vecs[i].exp);
      end

      // Logical right shift of a wrapped negative value: single pulse, then held 3 cycles
      held = bus.result;
      do_shift(1, held >> 1, "wrap1");
      do_shift(3, held >> 4, "wrap4");

      // start/shift pulsed mid-BUSY are ignored
      do_op(vecs[2].a, W'(3), 1'b0, 1'b1, 1'b0, "busy_disturb");

      // start with shift in DONE: new op, no shift
      do_op(W'(100), W'(58), 1'b1, 1'b0, 1'b1, "start_shift");

      // Reset at cycle 4 of BUSY
      bus.start = 1'b1;
      bus.subtract = 1'b0;
      bus.in_a = {W{1'b1}};
      bus.in_b = {W{1'b1}};
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_result", bus.result, (W+1)'(0));
      chk("midreset_done", (W+1)'(bus.done), (W+1)'(0));
      repeat (12) @(negedge clk);
      chk("midreset_idle_done", (W+1)'(bus.done), (W+1)'(0));
      chk("midreset_idle_result", bus.result, (W+1)'(0));
      do_op(W'(123456789), W'(987654321), 1'b0, 1'b0, 1'b0, "after_reset");

      // Random operations with random shift runs against the model
      for (int i = 0; i < 16; i++) begin
         ra = rand_w();
         rb = rand_w();
         if (i % 4 == 1) ra = rb;
         rs = $urandom_range(0, 1) == 1;
         do_op(ra, rb, rs, (i % 3) == 0, 1'b0, $sformatf("rnd%0d", i));
         k = $urandom_range(0, 3);
         if (k > 0) begin
            exp = ref_op(ra, rb, rs) >> k;
            do_shift(k, exp, $sformatf("rnd%0d", i));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder.md
# adder

Multi-precision 514-bit adder/subtractor for the RSA datapath, used by the Montgomery multiplier to accumulate partial sums and apply conditional modulus subtraction. It processes the operands word-serially over several cycles and holds a 515-bit result register. That register can be shifted right by one bit in place, which implements the Montgomery divide-by-2 step.

## Interface
- `WIDTH`, default 514: operand width in bits; the result is `WIDTH+1` bits.
- `WORD_W`, default 64: bits processed per cycle.
- `NWORDS`, derived as ceil((WIDTH+1)/WORD_W), 9 at the defaults; not overridable.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `start`  in  1: request a new operation. Sampled only in IDLE or DONE.
- `subtract`  in  1: 0 selects a+b, 1 selects a−b. Sampled with `start`.
- `shift`  in  1: one-cycle request for result >> 1. Honoured only when not BUSY.
- `in_a`  in  WIDTH: operand a. Captured on the edge that accepts `start`.
- `in_b`  in  WIDTH: operand b. Captured on the edge that accepts `start`.
- `result`  out  WIDTH+1: result register.
- `done`  out  1: high once the result is valid. Stays high until the next `start` is accepted or `reset`.

## Operation
- Operands are zero-extended to NWORDS·WORD_W bits.
  - Add computes a + b.
  - Subtract computes a + ~b + 1 (two's complement).
- `result` is the low WIDTH+1 bits of the operation, i.e. the value mod 2^(WIDTH+1).
  - An add carry lands in bit WIDTH; no overflow flag.
  - Subtract with a<b yields the 515-bit two's-complement wrap.
- Word-serial datapath:
  - Each cycle adds one WORD_W slice of A and (possibly inverted) B, plus a 1-bit carry register.
  - Slices are taken least-significant first.
  - The sum slice is written into the matching result slice.
  - The carry register is initialised to `subtract` when `start` is accepted.
- FSM states are IDLE, BUSY and DONE.
  - IDLE→BUSY on `start`: capture operands and `subtract`, clear the word counter, clear `result`, deassert `done`.
  - BUSY: process one word per cycle. After word NWORDS−1, go to DONE and set `done`=1.
  - DONE→BUSY on `start`, with the same actions as IDLE→BUSY.
- Shift:
  - In IDLE or DONE, `shift`=1 performs result ← {1'b0, result[WIDTH:1]} in one cycle. This is a logical shift.
  - `done` and the state are unchanged by a shift.
- Simultaneous events:
  - `start` and `shift` together: `start` wins and `shift` is dropped.
  - `start` or `shift` during BUSY: ignored.
  - `subtract`, `in_a` and `in_b` changing during BUSY have no effect.
- Reset at any time, including mid-operation, aborts the operation and sets state=IDLE, `result`=0, `done`=0, carry=0, counter=0.

## Timing
- Reset values: `result`=0, `done`=0, state IDLE.
- Let edge 0 be the edge that accepts `start`.
  - Words 0..NWORDS−1 are written on edges 1..NWORDS.
  - `done` is 1 after edge NWORDS: 9 cycles of latency at the defaults.
- `result` is final and stable whenever `done`=1. It changes only on an accepted `start`, a `shift` or a `reset`.
- `done` falls after the edge that accepts the next `start`.
- Shift result is visible after the edge that samples `shift`=1. Holding `shift` for k cycles shifts k bits.
- Back-to-back `start` pulses are allowed. A new `start` is accepted in the first cycle `done`=1.

## Structure
- Shared package holds:
  - RSA width constants: WIDTH=514, WORD_W=64, NWORDS.
  - The FSM state enum, which the Montgomery controller also uses.
- Natural sub-module `adder_word`: a combinational WORD_W-bit ripple/carry-chain slice with carry-in, optional B inversion, and carry-out.
- The top level holds the operand registers, word counter, carry register, result register, FSM and shift logic.

## Test plan
- 1+1 → after 9 cycles `done`=1, `result`=0x2. `done` stays 1 for at least 3 more idle cycles.
- Add of 0x26cabac…c72386 and 0x2a34bae…425a16a (large 514-bit vectors) → `result`=0x50ff75a…fecc4f0. A single `shift` pulse then yields that value >> 1.
- 1−1 → `result`=0. Then 0x3f12eada…8b63c139 − 0x3f6837b7…ef276754 → 0x7faab323…79c3c59e5 (515-bit wrap). Follow with a `shift` and check a logical right shift.
- Carry boundary: (2^514−1)+(2^514−1) → `result`=2^515−2, bit 514 set. Also 0−1 → all 515 bits set.
- `start` or `shift` pulsed during BUSY → ignored; result and latency unchanged. `start` together with `shift` in DONE → a new operation starts and no shift occurs.
- `reset` asserted at cycle 4 of BUSY → the next edge gives `result`=0, `done`=0, state IDLE. A fresh add then completes normally.
